// File: rtl/cv32e40s_pkg.sv
// Shared types for the OBI request path.
package cv32e40s_pkg;

    // Address-phase state of the OBI request driver
    typedef enum logic {
        IDLE,
        ADDR
    } obi_req_state_e;

    // Transfer fields held stable during the OBI address phase
    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_fields_t;

endpackage

// File: rtl/cv32e40s_obi_outstnd_cnt.sv
// Up/down counter of granted-but-unresponded OBI transfers, with a flag for
// responses that arrive while nothing is outstanding.
module cv32e40s_obi_outstnd_cnt #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             rvalid_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_next_o,
    output logic             protocol_err_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: +grant -response; a stray response never takes it below zero
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !rvalid_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!inc_i && rvalid_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o          = cnt_q;
    assign cnt_next_o     = cnt_d;
    assign protocol_err_o = rvalid_i && (cnt_q == '0);

endmodule

// File: rtl/cv32e40s_obi_req_ctrl.sv
// OBI address-phase driver: registers one transfer, holds it until granted,
// generates request parity, checks grant parity and bounds outstanding transfers.
module cv32e40s_obi_req_ctrl
    import cv32e40s_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_W          = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   trans_valid_i,
    output logic                                   trans_ready_o,
    input  logic [ADDR_W-1:0]                      trans_addr_i,
    input  logic                                   trans_we_i,
    input  logic [3:0]                             trans_be_i,
    input  logic [31:0]                            trans_wdata_i,
    output logic                                   obi_req_o,
    output logic                                   obi_reqpar_o,
    input  logic                                   obi_gnt_i,
    input  logic                                   obi_gntpar_i,
    output logic [ADDR_W-1:0]                      obi_addr_o,
    output logic                                   obi_we_o,
    output logic [3:0]                             obi_be_o,
    output logic [31:0]                            obi_wdata_o,
    input  logic                                   obi_rvalid_i,
    output logic                                   gntpar_err_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstnd_cnt_o,
    output logic                                   protocol_err_o
);

    localparam int unsigned            CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0]       MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    obi_req_state_e    state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    obi_req_fields_t   fields_q;
    logic [CNT_W-1:0]  cnt_next;
    logic              accept;

    cv32e40s_obi_outstnd_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_W           (CNT_W)
    ) u_outstnd_cnt (
        .clk            (clk),
        .rst            (rst),
        .inc_i          (obi_req_o && obi_gnt_i),
        .rvalid_i       (obi_rvalid_i),
        .cnt_o          (outstnd_cnt_o),
        .cnt_next_o     (cnt_next),
        .protocol_err_o (protocol_err_o)
    );

    // Ready depends only on req, gnt and the projected count, never on trans_*
    assign trans_ready_o = (!obi_req_o || obi_gnt_i) && (cnt_next < MAX_CNT);
    assign accept        = trans_valid_i && trans_ready_o;

    // Next state: an accept always (re)enters ADDR; a grant alone returns to IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = ADDR;
            ADDR: begin
                if (accept) begin
                    state_d = ADDR;
                end else if (obi_gnt_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and held address-phase fields; fields load only on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            fields_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q         <= trans_addr_i;
                fields_q.we    <= trans_we_i;
                fields_q.be    <= trans_be_i;
                fields_q.wdata <= trans_wdata_i;
            end
        end
    end

    assign obi_req_o    = (state_q == ADDR);
    assign obi_reqpar_o = ~obi_req_o;
    assign obi_addr_o   = addr_q;
    assign obi_we_o     = fields_q.we;
    assign obi_be_o     = fields_q.be;
    assign obi_wdata_o  = fields_q.wdata;

    // Grant parity is odd: a match between gnt and gntpar is an error
    assign gntpar_err_o = (obi_gntpar_i == obi_gnt_i);

    // Address phase must not change until granted
    a_stable_fields : assert property (@(posedge clk) disable iff (rst)
        (obi_req_o && !obi_gnt_i) |=> (obi_req_o && $stable(obi_addr_o) && $stable(obi_we_o) &&
                                       $stable(obi_be_o) && $stable(obi_wdata_o)));

    a_cnt_bound : assert property (@(posedge clk) disable iff (rst)
        outstnd_cnt_o <= MAX_CNT);

    a_reqpar : assert property (@(posedge clk) obi_reqpar_o == ~obi_req_o);

endmodule

// File: tb/tb_cv32e40s_obi_req_ctrl.sv
// Directed self-checking bench for cv32e40s_obi_req_ctrl (MAX_OUTSTANDING=2).
module tb_cv32e40s_obi_req_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        trans_valid_i;
    logic        trans_ready_o;
    logic [31:0] trans_addr_i;
    logic        trans_we_i;
    logic [3:0]  trans_be_i;
    logic [31:0] trans_wdata_i;
    logic        obi_req_o;
    logic        obi_reqpar_o;
    logic        obi_gnt_i;
    logic        obi_gntpar_i;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid_i;
    logic        gntpar_err_o;
    logic [1:0]  outstnd_cnt_o;
    logic        protocol_err_o;

    int n_checks = 0;
    int n_errors = 0;

    cv32e40s_obi_req_ctrl #(
        .MAX_OUTSTANDING (2),
        .ADDR_W          (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .trans_valid_i  (trans_valid_i),
        .trans_ready_o  (trans_ready_o),
        .trans_addr_i   (trans_addr_i),
        .trans_we_i     (trans_we_i),
        .trans_be_i     (trans_be_i),
        .trans_wdata_i  (trans_wdata_i),
        .obi_req_o      (obi_req_o),
        .obi_reqpar_o   (obi_reqpar_o),
        .obi_gnt_i      (obi_gnt_i),
        .obi_gntpar_i   (obi_gntpar_i),
        .obi_addr_o     (obi_addr_o),
        .obi_we_o       (obi_we_o),
        .obi_be_o       (obi_be_o),
        .obi_wdata_o    (obi_wdata_o),
        .obi_rvalid_i   (obi_rvalid_i),
        .gntpar_err_o   (gntpar_err_o),
        .outstnd_cnt_o  (outstnd_cnt_o),
        .protocol_err_o (protocol_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; sample 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_gnt(input logic g);
        obi_gnt_i    = g;
        obi_gntpar_i = ~g;
    endtask

    initial begin
        rst           = 1'b1;
        trans_valid_i = 1'b0;
        trans_addr_i  = '0;
        trans_we_i    = 1'b0;
        trans_be_i    = '0;
        trans_wdata_i = '0;
        obi_rvalid_i  = 1'b0;
        set_gnt(1'b0);
        #12;
        check("rst_req", obi_req_o, 1'b0);
        check("rst_reqpar", obi_reqpar_o, 1'b1);
        check("rst_addr", obi_addr_o, 32'h0);
        check("rst_cnt", outstnd_cnt_o, 2'd0);
        check("rst_perr", protocol_err_o, 1'b0);
        check("rst_gperr", gntpar_err_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // 1: single transfer, granted in the first req cycle
        trans_valid_i = 1'b1;
        trans_addr_i  = 32'hA000_0010;
        #1;
        check("t1_ready_idle", trans_ready_o, 1'b1);
        step();
        trans_valid_i = 1'b0;
        set_gnt(1'b1);
        #1;
        check("t1_req", obi_req_o, 1'b1);
        check("t1_reqpar", obi_reqpar_o, 1'b0);
        check("t1_addr", obi_addr_o, 32'hA000_0010);
        check("t1_cnt_before", outstnd_cnt_o, 2'd0);
        step();
        set_gnt(1'b0);
        check("t1_req_drop", obi_req_o, 1'b0);
        check("t1_cnt", outstnd_cnt_o, 2'd1);
        obi_rvalid_i = 1'b1;
        #1;
        check("t1_no_perr", protocol_err_o, 1'b0);
        step();
        obi_rvalid_i = 1'b0;
        check("t1_cnt_drain", outstnd_cnt_o, 2'd0);

        // 2: address phase held while gnt stays low and trans_* toggle
        trans_valid_i = 1'b1;
        trans_addr_i  = 32'hB000_0004;
        trans_we_i    = 1'b1;
        trans_be_i    = 4'hF;
        trans_wdata_i = 32'hDEAD_BEEF;
        step();
        for (int i = 0; i < 5; i++) begin
            trans_addr_i  = 32'h1000_0000 + 32'(i);
            trans_we_i    = i[0];
            trans_be_i    = 4'(i);
            trans_wdata_i = 32'h5555_0000 + 32'(i);
            #1;
            check("t2_ready", trans_ready_o, 1'b0);
            step();
            check("t2_req", obi_req_o, 1'b1);
            check("t2_addr", obi_addr_o, 32'hB000_0004);
            check("t2_we", obi_we_o, 1'b1);
            check("t2_be", obi_be_o, 4'hF);
            check("t2_wdata", obi_wdata_o, 32'hDEAD_BEEF);
        end
        trans_valid_i = 1'b0;
        set_gnt(1'b1);
        step();
        set_gnt(1'b0);
        check("t2_cnt", outstnd_cnt_o, 2'd1);
        check("t2_addr_kept", obi_addr_o, 32'hB000_0004);

        // 3: fill to MAX=2, then rvalid reopens ready in the same cycle
        trans_valid_i = 1'b1;
        trans_addr_i  = 32'hC000_0000;
        #1;
        check("t3_ready_cnt1", trans_ready_o, 1'b1);
        step();
        trans_valid_i = 1'b0;
        set_gnt(1'b1);
        step();
        set_gnt(1'b0);
        #1;
        check("t3_cnt_full", outstnd_cnt_o, 2'd2);
        check("t3_ready_full", trans_ready_o, 1'b0);
        obi_rvalid_i = 1'b1;
        #1;
        check("t3_ready_rvalid", trans_ready_o, 1'b1);
        step();
        check("t3_cnt_1", outstnd_cnt_o, 2'd1);
        step();
        obi_rvalid_i = 1'b0;
        check("t3_cnt_0", outstnd_cnt_o, 2'd0);

        // Back-to-back: accept in the grant cycle keeps req high with new fields
        trans_valid_i = 1'b1;
        trans_addr_i  = 32'hD000_0000;
        step();
        trans_addr_i = 32'hD000_0040;
        set_gnt(1'b1);
        #1;
        check("b2b_ready", trans_ready_o, 1'b1);
        step();
        trans_valid_i = 1'b0;
        check("b2b_req", obi_req_o, 1'b1);
        check("b2b_addr", obi_addr_o, 32'hD000_0040);
        check("b2b_cnt", outstnd_cnt_o, 2'd1);
        #1;
        check("b2b_ready_last", trans_ready_o, 1'b0);
        step();
        set_gnt(1'b0);
        check("b2b_cnt2", outstnd_cnt_o, 2'd2);
        check("b2b_req_drop", obi_req_o, 1'b0);
        obi_rvalid_i = 1'b1;
        step();
        step();
        obi_rvalid_i = 1'b0;
        check("b2b_drain", outstnd_cnt_o, 2'd0);

        // 4: grant parity compare
        obi_gnt_i    = 1'b1;
        obi_gntpar_i = 1'b1;
        #1;
        check("t4_gperr_g1p1", gntpar_err_o, 1'b1);
        obi_gnt_i = 1'b0;
        #1;
        check("t4_gperr_g0p1", gntpar_err_o, 1'b0);
        obi_gntpar_i = 1'b0;
        #1;
        check("t4_gperr_g0p0", gntpar_err_o, 1'b1);
        set_gnt(1'b0);
        #1;
        check("t4_gperr_ok", gntpar_err_o, 1'b0);

        // 5: response with nothing outstanding
        obi_rvalid_i = 1'b1;
        #1;
        check("t5_perr", protocol_err_o, 1'b1);
        step();
        obi_rvalid_i = 1'b0;
        check("t5_cnt", outstnd_cnt_o, 2'd0);
        #1;
        check("t5_perr_clr", protocol_err_o, 1'b0);

        // 6: async reset while req=1 and cnt=1
        trans_valid_i = 1'b1;
        trans_addr_i  = 32'hE000_0000;
        step();
        trans_addr_i = 32'hE000_0004;
        set_gnt(1'b1);
        step();
        trans_valid_i = 1'b0;
        set_gnt(1'b0);
        check("t6_pre_req", obi_req_o, 1'b1);
        check("t6_pre_cnt", outstnd_cnt_o, 2'd1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_req", obi_req_o, 1'b0);
        check("t6_reqpar", obi_reqpar_o, 1'b1);
        check("t6_cnt", outstnd_cnt_o, 2'd0);
        check("t6_addr", obi_addr_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        obi_rvalid_i = 1'b1;
        #1;
        check("t6_perr_after_rst", protocol_err_o, 1'b1);
        step();
        obi_rvalid_i = 1'b0;
        check("t6_cnt_after", outstnd_cnt_o, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
